// File: rtl/matrix_satd_acc.sv
// matrix_satd_acc: block SATD accumulator fed by the transformed column stream.
// Each accepted column is reduced to the sum of the absolute values of its
// 16 signed elements. COL_NUM of those column sums form one block SATD result.
// Block boundaries are tracked only by an internal column counter.
//
// Handshake rules (both ports): a beat moves on a rising edge where vld & rdy
// are both high. A producer holds vld and its data stable until that edge.
// rdy may be high while vld is low, and then it has no effect.
`timescale 1ns/1ps
module matrix_satd_acc #(
  parameter int DATA_WIDTH = 8,
  parameter int COL_NUM    = 16,
  parameter int SUM_WIDTH  = DATA_WIDTH + 12
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         tmp_col_vld,
  output logic                         tmp_col_rdy,
  input  logic [(DATA_WIDTH+4)*16-1:0] tmp_col_data,
  output logic                         satd_vld,
  input  logic                         satd_rdy,
  output logic [SUM_WIDTH-1:0]         satd_data
);

  localparam int EW  = DATA_WIDTH + 4;  // input element width
  localparam int S1W = DATA_WIDTH + 8;  // one column's abs sum, exact
  localparam int CW  = $clog2(COL_NUM);

  logic [CW-1:0]        col_cnt;
  logic                 s1_vld;
  logic                 s1_last;
  logic [S1W-1:0]       s1_sum;
  logic [S1W-1:0]       col_abs_sum;
  logic [SUM_WIDTH-1:0] acc;
  logic                 in_fire;
  logic                 s1_fire;

  // A non-last beat always drains into acc. A last beat waits only while the
  // output register still holds a result nobody has taken.
  assign s1_fire     = s1_vld & (~s1_last | ~satd_vld | satd_rdy);
  assign tmp_col_rdy = ~s1_vld | s1_fire;
  assign in_fire     = tmp_col_vld & tmp_col_rdy;

  // Sum of absolute values of the 16 elements. Each magnitude gets one extra
  // bit, so the most negative input keeps its exact magnitude.
  always_comb begin : abs_sum
    logic [EW:0] ext;
    logic [EW:0] mag;
    ext         = '0;
    mag         = '0;
    col_abs_sum = '0;
    for (int k = 0; k < 16; k++) begin
      ext         = {tmp_col_data[k*EW+EW-1], tmp_col_data[k*EW +: EW]};
      mag         = ext[EW] ? (~ext + (EW+1)'(1)) : ext;
      col_abs_sum = col_abs_sum + S1W'(mag);
    end
  end

  // Stage 1: register the column sum, tag the block's last column, and
  // advance the column counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_cnt <= '0;
      s1_vld  <= 1'b0;
      s1_sum  <= '0;
      s1_last <= 1'b0;
    end else if (in_fire) begin
      s1_sum  <= col_abs_sum;
      s1_last <= (col_cnt == CW'(COL_NUM - 1));
      col_cnt <= col_cnt + CW'(1);
      s1_vld  <= 1'b1;
    end else if (s1_fire) begin
      s1_vld  <= 1'b0;
    end
  end

  // Stage 2: accumulate a block. The last column closes the block into the
  // output register and restarts acc in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      satd_data <= '0;
    end else if (s1_fire) begin
      if (s1_last) begin
        satd_data <= acc + SUM_WIDTH'(s1_sum);
        acc       <= '0;
      end else begin
        acc       <= acc + SUM_WIDTH'(s1_sum);
      end
    end
  end

  // Output valid: a new result takes priority over the consumption of the
  // previous one in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      satd_vld <= 1'b0;
    end else if (s1_fire && s1_last) begin
      satd_vld <= 1'b1;
    end else if (satd_vld && satd_rdy) begin
      satd_vld <= 1'b0;
    end
  end

endmodule
